// File: rtl/mux_pkg.sv
// Shared definitions for the registered scanning multiplexer.
//   state_e     : controller state encoding (IDLE / MANUAL / SCAN)
//   MODE_MANUAL : mode input value selecting the external channel select
//   MODE_SCAN   : mode input value selecting the internal scan pointer
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage : mux_pkg

// File: rtl/mux_dwell_ctr.sv
// Dwell counter for the scan pointer: counts enabled scan cycles spent on the
// current channel and flags when the pointer should move on.
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   en_i      in   count this cycle (steady-state scan, enabled)
//   clear_i   in   restart counting from zero (scan entry)
//   dwell_i   in   cycles per channel minus one
//   advance_o out  pointer should advance on this edge
module mux_dwell_ctr #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               clear_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               advance_o
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;
    logic               at_limit_s;

    // ">=" rather than "==" so lowering dwell below the running count
    // advances at once instead of counting all the way round.
    assign at_limit_s = (cnt_q >= dwell_i);
    assign advance_o  = en_i & ~clear_i & at_limit_s;

    // Next-count selection: clear wins, then count/restart, else hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (at_limit_s) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + {{(DWELL_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : mux_dwell_ctr

// File: rtl/mux_scan_reg.sv
// Registered N-to-1 multiplexer with manual select and auto-scan modes.
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   a         in   packed channel data, channel i = a[i*W +: W]
//   en        in   enable; 0 freezes state and data outputs
//   mode      in   0 = manual select, 1 = scan through all channels
//   sel       in   manual channel select
//   dwell     in   scan cycles per channel minus one
//   out       out  registered selected data
//   out_sel   out  channel index that produced out
//   out_valid out  out/out_sel were refreshed on the last edge
//   sel_err   out  manual select was out of range
//   wrap      out  scan pointer wrapped from the last channel to 0
module mux_scan_reg
    import mux_pkg::*;
#(
    parameter int N_CH    = 8,
    parameter int W       = 1,
    parameter int SEL_W   = $clog2(N_CH),
    parameter int DWELL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] a,
    input  logic              en,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [W-1:0]      out,
    output logic [SEL_W-1:0]  out_sel,
    output logic              out_valid,
    output logic              sel_err,
    output logic              wrap
);

    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);
    localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W+1)'(N_CH);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [W-1:0]       out_q, out_d;
    logic [SEL_W-1:0]   out_sel_q, out_sel_d;
    logic               out_valid_q, out_valid_d;
    logic               sel_err_q, sel_err_d;
    logic               wrap_q, wrap_d;

    logic [W-1:0]       man_data_s;
    logic [W-1:0]       scan_data_s;
    logic               sel_oor_s;
    logic               scan_entry_s;
    logic               scan_step_s;
    logic               advance_s;

    // Compare with one extra bit so N_CH itself is representable.
    assign sel_oor_s    = ({1'b0, sel} >= N_CH_EXT);
    // Entering scan from anywhere else always restarts at channel 0.
    assign scan_entry_s = en && (mode == MODE_SCAN) && (state_q != SCAN);
    assign scan_step_s  = en && (mode == MODE_SCAN) && (state_q == SCAN);

    mux_dwell_ctr #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (scan_step_s),
        .clear_i   (scan_entry_s),
        .dwell_i   (dwell),
        .advance_o (advance_s)
    );

    // Channel muxes; only indices below N_CH can ever contribute.
    always_comb begin
        man_data_s  = '0;
        scan_data_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            man_data_s  = man_data_s  | ({W{sel   == SEL_W'(i)}} & a[i*W +: W]);
            scan_data_s = scan_data_s | ({W{ptr_q == SEL_W'(i)}} & a[i*W +: W]);
        end
    end

    // Next state: disable dominates, otherwise mode picks the state.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else if (mode == MODE_SCAN) begin
            state_d = SCAN;
        end else begin
            state_d = MANUAL;
        end
    end

    // Datapath next values; decided from the inputs of this edge so the new
    // mode's first sample lands on the same edge as the state change.
    always_comb begin
        out_d       = out_q;
        out_sel_d   = out_sel_q;
        out_valid_d = 1'b0;
        sel_err_d   = sel_err_q;
        wrap_d      = 1'b0;
        ptr_d       = ptr_q;
        if (!en) begin
            out_valid_d = 1'b0;
        end else if (mode == MODE_MANUAL) begin
            out_sel_d   = sel;
            out_valid_d = 1'b1;
            if (sel_oor_s) begin
                out_d     = '0;
                sel_err_d = 1'b1;
            end else begin
                out_d     = man_data_s;
                sel_err_d = 1'b0;
            end
        end else if (scan_entry_s) begin
            ptr_d       = '0;
            out_d       = a[W-1:0];
            out_sel_d   = '0;
            out_valid_d = 1'b1;
            sel_err_d   = 1'b0;
        end else begin
            out_d       = scan_data_s;
            out_sel_d   = ptr_q;
            out_valid_d = 1'b1;
            sel_err_d   = 1'b0;
            if (advance_s) begin
                if (ptr_q == LAST_CH) begin
                    ptr_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    ptr_d  = ptr_q + SEL_W'(1);
                end
            end else begin
                ptr_d = ptr_q;
            end
        end
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            out_q       <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_q       <= out_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            wrap_q      <= wrap_d;
        end
    end

    assign out       = out_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;
    assign wrap      = wrap_q;

endmodule : mux_scan_reg

// File: tb/tb_mux_scan_reg.sv
// Directed bench for mux_scan_reg: an 8x1 instance for manual/scan/freeze/
// dwell/reset sequences and a 6x4 instance for out-of-range selects.
module tb_mux_scan_reg;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [3:0]  dwell;

    logic [7:0]  a_a;
    logic [2:0]  sel_a;
    logic [0:0]  out_a;
    logic [2:0]  out_sel_a;
    logic        valid_a, err_a, wrap_a;

    logic [23:0] a_b;
    logic [2:0]  sel_b;
    logic [3:0]  out_b;
    logic [2:0]  out_sel_b;
    logic        valid_b, err_b, wrap_b;

    int total;
    int passed;

    typedef struct {
        logic [2:0] sel_a;
        logic       exp_a;
        logic [2:0] sel_b;
        logic [3:0] exp_b;
        logic       err_b;
    } man_vec_t;

    man_vec_t vecs [8];

    mux_scan_reg #(.N_CH(8), .W(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a_a), .en(en), .mode(mode), .sel(sel_a),
        .dwell(dwell), .out(out_a), .out_sel(out_sel_a), .out_valid(valid_a),
        .sel_err(err_a), .wrap(wrap_a)
    );

    mux_scan_reg #(.N_CH(6), .W(4)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .a(a_b), .en(en), .mode(mode), .sel(sel_b),
        .dwell(dwell), .out(out_b), .out_sel(out_sel_b), .out_valid(valid_b),
        .sel_err(err_b), .wrap(wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_sel;
        logic [2:0] seq [4];
        total  = 0;
        passed = 0;

        // ch0..ch5 of the 6x4 instance = 1,3,A,5,C,E
        vecs[0] = '{3'd0, 1'b1, 3'd7, 4'h0, 1'b1};
        vecs[1] = '{3'd1, 1'b1, 3'd2, 4'hA, 1'b0};
        vecs[2] = '{3'd2, 1'b1, 3'd6, 4'h0, 1'b1};
        vecs[3] = '{3'd3, 1'b1, 3'd5, 4'hE, 1'b0};
        vecs[4] = '{3'd4, 1'b0, 3'd0, 4'h1, 1'b0};
        vecs[5] = '{3'd5, 1'b1, 3'd7, 4'h0, 1'b1};
        vecs[6] = '{3'd6, 1'b0, 3'd3, 4'h5, 1'b0};
        vecs[7] = '{3'd7, 1'b1, 3'd4, 4'hC, 1'b0};

        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        dwell = 4'd0;
        sel_a = 3'd0;
        sel_b = 3'd0;
        a_a   = 8'b10101111;
        a_b   = 24'hEC5A31;

        // Reset state
        #12;
        check("rst_out",     32'(out_a),     32'd0);
        check("rst_out_sel", 32'(out_sel_a), 32'd0);
        check("rst_valid",   32'(valid_a),   32'd0);
        check("rst_err",     32'(err_a),     32'd0);
        check("rst_wrap",    32'(wrap_a),    32'd0);
        check("rst_out_b",   32'(out_b),     32'd0);
        rst_n = 1'b1;
        tick();

        // Manual sweep (both instances)
        en   = 1'b1;
        mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sel_a = vecs[i].sel_a;
            sel_b = vecs[i].sel_b;
            tick();
            check("man_out",     32'(out_a),     32'(vecs[i].exp_a));
            check("man_out_sel", 32'(out_sel_a), 32'(vecs[i].sel_a));
            check("man_valid",   32'(valid_a),   32'd1);
            check("man_err",     32'(err_a),     32'd0);
            check("oor_out",     32'(out_b),     32'(vecs[i].exp_b));
            check("oor_out_sel", 32'(out_sel_b), 32'(vecs[i].sel_b));
            check("oor_err",     32'(err_b),     32'(vecs[i].err_b));
        end

        // Scan with dwell=1: entry edge then 0,0,1,1,...,7,7 with wrap on the second 7
        mode  = 1'b1;
        dwell = 4'd1;
        tick();
        check("scan_entry_sel",   32'(out_sel_a), 32'd0);
        check("scan_entry_out",   32'(out_a),     32'(a_a[0]));
        check("scan_entry_valid", 32'(valid_a),   32'd1);
        check("scan_entry_err_b", 32'(err_b),     32'd0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp_sel = (k <= 16) ? (k - 1) / 2 : 0;
            check("scan_sel",  32'(out_sel_a), 32'(exp_sel));
            check("scan_out",  32'(out_a),     32'(a_a[exp_sel]));
            check("scan_wrap", 32'(wrap_a),    32'(k == 16));
        end

        // Re-enter scan via manual, run to out_sel=3, then freeze
        mode = 1'b0;
        tick();
        mode = 1'b1;
        tick();
        for (int k = 1; k <= 7; k++) tick();
        check("pre_freeze_sel", 32'(out_sel_a), 32'd3);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("frz_sel",   32'(out_sel_a), 32'd3);
            check("frz_out",   32'(out_a),     32'(a_a[3]));
            check("frz_valid", 32'(valid_a),   32'd0);
        end
        en = 1'b1;
        tick();
        check("resume_sel",   32'(out_sel_a), 32'd0);
        check("resume_valid", 32'(valid_a),   32'd1);

        // Dwell lowered below the running count advances at once
        dwell = 4'd15;
        for (int k = 1; k <= 9; k++) tick();
        check("dw15_sel", 32'(out_sel_a), 32'd0);
        dwell = 4'd2;
        tick();
        check("dw_drop_sel", 32'(out_sel_a), 32'd0);
        seq[0] = 3'd1; seq[1] = 3'd1; seq[2] = 3'd1; seq[3] = 3'd2;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("dw2_sel", 32'(out_sel_a), 32'(seq[k]));
        end

        // Dwell 0 to reach ptr=5, then async reset mid-scan
        dwell = 4'd0;
        seq[0] = 3'd2; seq[1] = 3'd3; seq[2] = 3'd4;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("dw0_sel", 32'(out_sel_a), 32'(seq[k]));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_sel", 32'(out_sel_a), 32'd0);
        check("async_rst_valid",   32'(valid_a),   32'd0);
        check("async_rst_wrap",    32'(wrap_a),    32'd0);
        check("async_rst_out_b",   32'(out_b),     32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        check("post_rst_sel",   32'(out_sel_a), 32'd0);
        check("post_rst_valid", 32'(valid_a),   32'd1);
        tick();
        check("post_rst_hold0", 32'(out_sel_a), 32'd0);
        tick();
        check("post_rst_adv",   32'(out_sel_a), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_mux_scan_reg
